mmio_port_controller: RTL
=========================

// Module: mmio_port_controller
// PURPOSE
//  Memory-mapped I/O block on the MEM stage, beside the data RAM. Consumes the EX/MEM address, store data and MemWrite/MemRead.
//  Drives PortOut from a register and presents a debounced PortIn with change detection and an interrupt flag.
//  Top level muxes ReadData over RAM data and gates RAM MemWrite off whenever IOSelect=1.
// PARAMETERS
//  BASE_ADDR       32'hFFFF_0000  I/O window base; must be 16-byte aligned; window is 4 words
//  PORT_IN_WIDTH   8              PortIn width; zero-extended to 32 on read
//  DEBOUNCE_CYCLES 4              cycles the synced input must differ from the accepted value before acceptance (>=1)
//  COUNT_WIDTH     8              width of the saturating change counter
// PORTS
//  clk        in   1   clock; all state updates on its rising edge
//  reset      in   1   synchronous, active-high reset
//  Address    in   32  byte address from ALU result (MEM stage)
//  WriteData  in   32  store data (rt)
//  MemWrite   in   1   store strobe
//  MemRead    in   1   load strobe
//  PortIn     in   PORT_IN_WIDTH  external input; asynchronous to clk
//  ReadData   out  32  load data; 0 unless MemRead & IOSelect
//  IOSelect   out  1   Address[31:4]==BASE_ADDR[31:4] (combinational)
//  PortOut    out  32  PORT_OUT register
//  IRQ        out  1   CHANGED & IRQ_EN
// BEHAVIOUR
//  Register map, offsets from BASE_ADDR; Address[1:0] ignored:
//   0x0 PORT_OUT  RW  32-bit
//   0x4 PORT_IN   RO  accepted (debounced) value, zero-extended; writes ignored
//   0x8 STATUS    [0] CHANGED sticky, [1] OVERFLOW sticky, [8+:COUNT_WIDTH] COUNT, others 0
//                 write: bit0=1 clears CHANGED; bit1=1 clears OVERFLOW; bit31=1 clears COUNT; 0 bits no effect
//   0xC CONTROL   RW  [0] IRQ_EN; other bits read 0
//  Reads are combinational from registers, zero latency, no side effects (same timing as RAM read).
//  Writes take effect on the edge where MemWrite & IOSelect; visible on outputs the next cycle.
//  MemWrite & MemRead together: the read returns the old value; the write commits at the edge.
//  Reset (edge with reset=1): PORT_OUT=0, IRQ_EN=0, CHANGED=0, OVERFLOW=0, COUNT=0, sync FFs=0, accepted=0, debounce counter=0.
//   Outputs after reset: PortOut=0, IRQ=0, ReadData=0 unless selected.
//  Input path: 2-FF synchronizer (sync1, sync2) -> debounce -> accepted register.
//  Debounce counter:
//   sync2==accepted: counter<=0.
//   sync2!=accepted and counter<DEBOUNCE_CYCLES-1: counter++.
//   sync2!=accepted and counter==DEBOUNCE_CYCLES-1: accepted<=sync2, counter<=0, raise a change event this edge.
//   A glitch shorter than DEBOUNCE_CYCLES synced cycles resets the count; no event.
//  Latency: PortIn stable before edge E is accepted at edge E+1+DEBOUNCE_CYCLES; STATUS/IRQ update at the same edge.
//  Change event, without a same-cycle clear:
//   CHANGED<=1; OVERFLOW<=1 if CHANGED was already 1; COUNT<=COUNT+1, saturating at all-ones.
//  Change event on the same edge as a STATUS write:
//   bit0=1: CHANGED stays 1 (set wins), OVERFLOW not set by this event.
//   bit31=1: COUNT<=1.
//  Reset mid-operation: all state cleared, in-progress debounce discarded.
//   A nonzero PortIn held through reset produces an event DEBOUNCE_CYCLES+2 edges after reset deasserts.
//  IRQ is combinational from the CHANGED and IRQ_EN registers; clearing either deasserts it the next cycle.
// TESTING
//  1 reset 2 cycles, PortIn=8'hA5, D=4 -> PortOut=0, IRQ=0; CHANGED=1 exactly 6 edges after release; PORT_IN reads 32'h000000A5.
//  2 store 32'hDEADBEEF to FFFF_0000 -> PortOut=DEADBEEF next cycle, load returns it; store to FFFF_0010 -> IOSelect=0, PortOut unchanged.
//  3 D=4: PortIn 0->1 for 3 cycles then 0 -> no event, COUNT=0; hold 1 for 8 cycles -> one event, COUNT=1, PORT_IN=1.
//  4 two accepted changes, no clear -> STATUS=32'h00000203 (COUNT=2); store 32'h3 to 0x8 -> STATUS=32'h00000200.
//  5 store bit0 on the same edge as an event -> CHANGED=1, OVERFLOW=0; CONTROL=1 -> IRQ=1; clear CHANGED -> IRQ=0 next cycle.
//  6 300 accepted toggles -> COUNT=8'hFF, OVERFLOW=1; store 32'h8000_0000 to 0x8 -> COUNT=0, CHANGED/OVERFLOW unchanged.

Source files
------------

// File: rtl/mmio_port_controller.sv
// ---------------------------------------------------------------------------
// mmio_port_controller
// Memory-mapped I/O block sitting beside the data RAM in the MEM stage.
// Owns a 32-bit output port register and a debounced, change-detecting
// input port with a sticky change flag, overflow flag, saturating change
// counter and an interrupt enable.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : synchronous, active-high reset
//   Address    : byte address from the MEM stage (bits [1:0] ignored)
//   WriteData  : store data
//   MemWrite   : store strobe
//   MemRead    : load strobe
//   PortIn     : external input, asynchronous to clk
//   ReadData   : load data, zero unless MemRead & IOSelect (combinational)
//   IOSelect   : address falls in the 4-word I/O window (combinational)
//   PortOut    : PORT_OUT register
//   IRQ        : CHANGED & IRQ_EN (combinational from registers)
//
// Register map (offset from BASE_ADDR)
//   0x0 PORT_OUT  RW
//   0x4 PORT_IN   RO, accepted value zero-extended
//   0x8 STATUS    [0] CHANGED, [1] OVERFLOW, [8+:COUNT_WIDTH] COUNT
//                 write 1 to bit0/bit1/bit31 clears CHANGED/OVERFLOW/COUNT
//   0xC CONTROL   [0] IRQ_EN
// ---------------------------------------------------------------------------
module mmio_port_controller #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int unsigned PORT_IN_WIDTH   = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Address,
    input  logic [31:0]              WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic [31:0]              ReadData,
    output logic                     IOSelect,
    output logic [31:0]              PortOut,
    output logic                     IRQ
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_CONTROL  = 2'd3;

    logic [31:0]              port_out_q, port_out_d;
    logic                     irq_en_q,   irq_en_d;
    logic                     changed_q,  changed_d;
    logic                     overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0]   count_q,    count_d;
    logic [PORT_IN_WIDTH-1:0] sync1_q,    sync1_d;
    logic [PORT_IN_WIDTH-1:0] sync2_q,    sync2_d;
    logic [PORT_IN_WIDTH-1:0] accepted_q, accepted_d;
    logic [DBW-1:0]           deb_cnt_q,  deb_cnt_d;

    logic        change_ev;
    logic        wr_en;
    logic [1:0]  reg_off;
    logic        clr_changed;
    logic        clr_overflow;
    logic        clr_count;
    logic [31:0] status_word;
    logic        unused_addr_bits;

    // Word offset only; byte lane bits do not select anything.
    assign unused_addr_bits = ^Address[1:0];

    assign IOSelect = (Address[31:4] == BASE_ADDR[31:4]);
    assign reg_off  = Address[3:2];
    assign wr_en    = MemWrite & IOSelect;

    assign clr_changed  = wr_en && (reg_off == OFF_STATUS) && WriteData[0];
    assign clr_overflow = wr_en && (reg_off == OFF_STATUS) && WriteData[1];
    assign clr_count    = wr_en && (reg_off == OFF_STATUS) && WriteData[31];

    // Next-state logic: synchronizer, debounce, status and register writes.
    always_comb begin
        port_out_d = port_out_q;
        irq_en_d   = irq_en_q;
        changed_d  = changed_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        accepted_d = accepted_q;
        deb_cnt_d  = deb_cnt_q;
        sync1_d    = PortIn;
        sync2_d    = sync1_q;
        change_ev  = 1'b0;

        // Any return to the accepted value restarts the qualification window.
        if (sync2_q == accepted_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            accepted_d = sync2_q;
            deb_cnt_d  = '0;
            change_ev  = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
        end

        // A new event always wins over a same-edge clear of CHANGED.
        if (change_ev) begin
            changed_d = 1'b1;
        end else if (clr_changed) begin
            changed_d = 1'b0;
        end

        // OVERFLOW marks an event that landed on an unacknowledged CHANGED.
        overflow_d = (change_ev & changed_q & ~clr_changed) | (overflow_q & ~clr_overflow);

        if (clr_count) begin
            count_d = change_ev ? COUNT_WIDTH'(1) : '0;
        end else if (change_ev && !(&count_q)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        if (wr_en) begin
            case (reg_off)
                OFF_PORT_OUT: port_out_d = WriteData;
                OFF_CONTROL:  irq_en_d   = WriteData[0];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q <= '0;
            irq_en_q   <= 1'b0;
            changed_q  <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            accepted_q <= '0;
            deb_cnt_q  <= '0;
        end else begin
            port_out_q <= port_out_d;
            irq_en_q   <= irq_en_d;
            changed_q  <= changed_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            accepted_q <= accepted_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // Read path: zero-latency mux of register contents.
    always_comb begin
        status_word                    = '0;
        status_word[0]                 = changed_q;
        status_word[1]                 = overflow_q;
        status_word[8 +: COUNT_WIDTH]  = count_q;

        ReadData = '0;
        if (MemRead && IOSelect) begin
            case (reg_off)
                OFF_PORT_OUT: ReadData = port_out_q;
                OFF_PORT_IN:  ReadData = 32'(accepted_q);
                OFF_STATUS:   ReadData = status_word;
                OFF_CONTROL:  ReadData = {31'd0, irq_en_q};
                default:      ReadData = '0;
            endcase
        end
    end

    assign PortOut = port_out_q;
    assign IRQ     = changed_q & irq_en_q;

endmodule
